// File: rtl/tdm_mux_8to1_rr_pkg.sv
// Shared definitions for the 8-lane TDM mux/demux pair.
package tdm_mux_8to1_rr_pkg;
  localparam int N_CH   = 8;
  localparam int SEL_W  = 3;
  localparam int DATA_W = 8;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_e;
endpackage

// File: rtl/tdm_mux_8to1_rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or after ptr wins.
module rr_arbiter_8 (
  input  logic [7:0] req,
  input  logic [2:0] ptr,
  input  logic       en,
  output logic [7:0] gnt_onehot,
  output logic [2:0] gnt_idx,
  output logic       gnt_any
);
  logic [2:0] idx;

  always_comb begin
    gnt_onehot = '0;
    gnt_idx    = '0;
    gnt_any    = 1'b0;
    idx        = '0;
    // 3-bit index arithmetic wraps the search past lane 7 back to lane 0
    for (int i = 0; i < 8; i++) begin
      idx = ptr + 3'(i);
      if (en && !gnt_any && req[idx]) begin
        gnt_any         = 1'b1;
        gnt_idx         = idx;
        gnt_onehot[idx] = 1'b1;
      end
    end
  end
endmodule

// File: rtl/tdm_mux_8to1_rr.sv
// Round-robin 8:1 merge of valid/ready lanes into one registered, channel-tagged stream.
module tdm_mux_8to1_rr
  import tdm_mux_8to1_rr_pkg::*;
#(
  parameter int N_CH_P   = N_CH,
  parameter int SEL_W_P  = SEL_W,
  parameter int DATA_W_P = DATA_W
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [N_CH_P*DATA_W_P-1:0] in_data,
  input  logic [N_CH_P-1:0]          in_valid,
  output logic [N_CH_P-1:0]          in_ready,
  output logic [DATA_W_P-1:0]        out_data,
  output logic [SEL_W_P-1:0]         out_sel,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [15:0]                grant_cnt
);
  state_e            state, state_nxt;
  logic [SEL_W_P-1:0] ptr;
  logic              load;
  logic [N_CH_P-1:0] gnt_onehot;
  logic [SEL_W_P-1:0] gnt_idx;
  logic              gnt_any;

  assign out_valid = (state == ST_FULL);
  assign load      = (state == ST_EMPTY) || (out_valid && out_ready);

  // rst_n gate keeps in_ready low while reset is held (state reads EMPTY then)
  rr_arbiter_8 u_arb (
    .req       (in_valid),
    .ptr       (ptr),
    .en        (load && rst_n),
    .gnt_onehot(gnt_onehot),
    .gnt_idx   (gnt_idx),
    .gnt_any   (gnt_any)
  );

  assign in_ready = gnt_onehot;

  always_comb begin
    state_nxt = state;
    if (load) state_nxt = gnt_any ? ST_FULL : ST_EMPTY;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_EMPTY;
      ptr       <= '0;
      out_data  <= '0;
      out_sel   <= '0;
      grant_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (gnt_any) begin
        out_data  <= in_data[gnt_idx*DATA_W_P +: DATA_W_P];
        out_sel   <= gnt_idx;
        ptr       <= gnt_idx + SEL_W_P'(1);
        grant_cnt <= grant_cnt + 16'd1;
      end
    end
  end
endmodule

// File: tb/tb_tdm_mux_8to1_rr.sv
// Directed self-checking bench for tdm_mux_8to1_rr.
module tb_tdm_mux_8to1_rr;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [63:0] in_data;
  logic [7:0]  in_valid;
  logic [7:0]  in_ready;
  logic [7:0]  out_data;
  logic [2:0]  out_sel;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] grant_cnt;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  tdm_mux_8to1_rr dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .out_data (out_data),
    .out_sel  (out_sel),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .grant_cnt(grant_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_data(input logic [7:0] base);
    for (int k = 0; k < 8; k++) in_data[k*8 +: 8] = base + 8'(k);
  endtask

  initial begin
    // reset with random inputs
    rst_n     = 1'b0;
    in_data   = {$urandom, $urandom};
    in_valid  = 8'($urandom);
    out_ready = 1'($urandom);
    repeat (3) step();
    in_valid = 8'hFF;
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'h0);
    chk("rst_out_valid", 32'(out_valid), 32'h0);
    chk("rst_out_sel", 32'(out_sel), 32'h0);
    chk("rst_out_data", 32'(out_data), 32'h0);
    chk("rst_grant_cnt", 32'(grant_cnt), 32'h0);

    // all lanes requesting: strict 0..7 rotation, no gaps
    set_data(8'h10);
    in_valid  = 8'hFF;
    out_ready = 1'b1;
    rst_n     = 1'b1;
    #1;
    chk("first_grant_lane0", 32'(in_ready), 32'h01);
    for (int i = 0; i < 16; i++) begin
      chk("all_in_ready", 32'(in_ready), 32'(8'h01 << (i % 8)));
      step();
      chk("all_out_sel", 32'(out_sel), 32'(i % 8));
      chk("all_out_data", 32'(out_data), 32'(8'h10 + 8'(i % 8)));
      chk("all_out_valid", 32'(out_valid), 32'h1);
    end
    chk("all_grant_cnt", 32'(grant_cnt), 32'd16);
    in_valid = 8'h00;
    #1;
    chk("drain_no_ready", 32'(in_ready), 32'h0);
    step();
    chk("drain_clears_valid", 32'(out_valid), 32'h0);

    // single lane 5
    in_data[5*8 +: 8] = 8'hA5;
    in_valid = 8'b0010_0000;
    #1;
    chk("single_in_ready", 32'(in_ready), 32'h20);
    step();
    chk("single_out_data", 32'(out_data), 32'hA5);
    chk("single_out_sel", 32'(out_sel), 32'd5);
    chk("single_out_valid", 32'(out_valid), 32'h1);
    in_valid = 8'h00;
    #1;
    chk("single_ready_drop", 32'(in_ready), 32'h0);
    step();
    chk("single_drained", 32'(out_valid), 32'h0);

    // lane 1 grant moves ptr to 2
    in_valid = 8'b0000_0010;
    step();
    chk("lane1_out_sel", 32'(out_sel), 32'd1);
    in_valid = 8'h00;
    step();

    // backpressure with lanes 2 and 6
    set_data(8'h30);
    in_valid  = 8'b0100_0100;
    out_ready = 1'b0;
    #1;
    chk("bp_first_ready", 32'(in_ready), 32'h04);
    step();
    chk("bp_load_sel", 32'(out_sel), 32'd2);
    chk("bp_load_data", 32'(out_data), 32'h32);
    for (int i = 0; i < 5; i++) begin
      chk("bp_in_ready", 32'(in_ready), 32'h0);
      step();
      chk("bp_hold_sel", 32'(out_sel), 32'd2);
      chk("bp_hold_data", 32'(out_data), 32'h32);
      chk("bp_hold_valid", 32'(out_valid), 32'h1);
    end
    out_ready = 1'b1;
    #1;
    chk("bp_release_ready", 32'(in_ready), 32'h40);
    step();
    chk("bp_next_sel6", 32'(out_sel), 32'd6);
    chk("bp_next_data6", 32'(out_data), 32'h36);
    chk("bp_then_ready2", 32'(in_ready), 32'h04);
    step();
    chk("bp_then_sel2", 32'(out_sel), 32'd2);
    in_valid = 8'h00;
    step();
    chk("bp_drained", 32'(out_valid), 32'h0);
    chk("bp_grant_cnt", 32'(grant_cnt), 32'd21);

    // asynchronous reset while holding lane 3
    in_valid  = 8'b0000_1000;
    out_ready = 1'b0;
    step();
    chk("mid_sel3", 32'(out_sel), 32'd3);
    chk("mid_valid", 32'(out_valid), 32'h1);
    in_valid = 8'h00;
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(out_valid), 32'h0);
    chk("mid_rst_cnt", 32'(grant_cnt), 32'h0);
    chk("mid_rst_sel", 32'(out_sel), 32'h0);
    in_valid = 8'hFF;
    #1;
    chk("mid_rst_in_ready", 32'(in_ready), 32'h0);
    step();

    // release with all lanes: ptr back to 0, then run to counter wrap
    set_data(8'h10);
    out_ready = 1'b1;
    rst_n     = 1'b1;
    #1;
    chk("post_rst_ptr0", 32'(in_ready), 32'h01);
    repeat (65535) step();
    chk("wrap_cnt_ffff", 32'(grant_cnt), 32'hFFFF);
    chk("wrap_pre_sel", 32'(out_sel), 32'd6);
    step();
    chk("wrap_cnt_zero", 32'(grant_cnt), 32'h0);
    chk("wrap_sel", 32'(out_sel), 32'd7);
    chk("wrap_data", 32'(out_data), 32'h17);
    chk("wrap_valid", 32'(out_valid), 32'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
